// File: rtl/ncl_instr_sequencer.sv
// Queues 8-bit instruction words and issues each one as a dual-rail DATA/NULL
// handshake to an NCL controller, returning the masked completion rails.
module ncl_instr_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 200,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] i_t,
    output logic [7:0] i_f,
    input  logic [9:0] c_t,
    input  logic [9:0] c_f,
    output logic       done,
    output logic [9:0] resp,
    output logic       busy,
    input  logic       err_clr,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic       err_conflict
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StData, StNullw, StAbort} state_e;

    function automatic logic [9:0] mask_of(input logic [1:0] op);
        case (op)
            2'b11:   return 10'b11_1111_1110;
            2'b00:   return 10'b00_0000_0000;
            default: return 10'b11_1000_0001;
        endcase
    endfunction

    // Instruction queue
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            full, empty, push, pop;
    logic [7:0]      head;
    logic            head_legal;

    assign full       = (count_q == FullCnt);
    assign empty      = (count_q == '0);
    assign in_ready   = ~full;
    assign push       = in_valid & ~full;
    assign head       = mem_q[rd_ptr_q];
    assign head_legal = |head[7:6];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Two-flop synchroniser on the returned rails
    logic [9:0] t_meta_q, f_meta_q, st, sf;

    always_ff @(posedge clk) begin
        if (rst) begin
            t_meta_q <= '0;
            f_meta_q <= '0;
            st       <= '0;
            sf       <= '0;
        end else begin
            t_meta_q <= c_t;
            f_meta_q <= c_f;
            st       <= t_meta_q;
            sf       <= f_meta_q;
        end
    end

    state_e     state_q;
    logic [7:0] cyc_q;
    logic [9:0] mask_q;
    logic       data_ok, null_ok, at_limit;
    logic       set_illegal, set_timeout, set_conflict;

    assign data_ok  = (((st ^ sf) & mask_q) == mask_q);
    // The synchroniser needs two cycles to reflect rails after any NULL
    // request or reset, so an all-low reading is only trusted after that.
    assign null_ok  = ~|{st, sf} && (cyc_q >= 8'd2);
    assign at_limit = (cyc_q == TimeoutLast);
    assign pop      = (state_q == StIdle) && !empty;
    assign busy     = (state_q != StIdle) || !empty;

    assign set_illegal  = pop && !head_legal;
    assign set_timeout  = at_limit && (((state_q == StData) && !data_ok) ||
                                       ((state_q == StNullw) && !null_ok));
    assign set_conflict = |(st & sf);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StNullw;
            cyc_q        <= '0;
            mask_q       <= '0;
            i_t          <= '0;
            i_f          <= '0;
            done         <= 1'b0;
            resp         <= '0;
            err_illegal  <= 1'b0;
            err_timeout  <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            done         <= 1'b0;
            err_illegal  <= (err_illegal & ~err_clr) | set_illegal;
            err_timeout  <= (err_timeout & ~err_clr) | set_timeout;
            err_conflict <= (err_conflict & ~err_clr) | set_conflict;
            unique case (state_q)
                StIdle: begin
                    cyc_q <= '0;
                    if (!empty) begin
                        if (head_legal) begin
                            i_t     <= head;
                            i_f     <= ~head;
                            mask_q  <= mask_of(head[7:6]);
                            state_q <= StData;
                        end else begin
                            done <= 1'b1;
                            resp <= '0;
                        end
                    end
                end
                StData: begin
                    if (data_ok) begin
                        resp    <= st & mask_q;
                        done    <= 1'b1;
                        i_t     <= '0;
                        i_f     <= '0;
                        cyc_q   <= '0;
                        state_q <= StNullw;
                    end else if (at_limit) begin
                        i_t     <= '0;
                        i_f     <= '0;
                        cyc_q   <= '0;
                        state_q <= StAbort;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                StNullw: begin
                    if (null_ok) begin
                        cyc_q   <= '0;
                        state_q <= StIdle;
                    end else if (at_limit) begin
                        cyc_q   <= '0;
                        state_q <= StAbort;
                    end else begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                StAbort: begin
                    // Once timed out here, park the counter and just wait.
                    if (null_ok) begin
                        cyc_q   <= '0;
                        state_q <= StIdle;
                    end else if (!at_limit) begin
                        cyc_q <= cyc_q + 8'd1;
                    end
                end
                default: state_q <= StNullw;
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_instr_sequencer.sv
// Randomised and directed bench for ncl_instr_sequencer against a
// cycle-stepped reference model of the queue/handshake rules.
module tb_ncl_instr_sequencer;

    localparam int TO    = 16;
    localparam int DEPTH = 4;
    localparam int PH_IDLE = 0, PH_DATA = 1, PH_NULL = 2, PH_ABORT = 3;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, done, busy, err_clr;
    logic       err_illegal, err_timeout, err_conflict;
    logic [7:0] in_data, i_t, i_f;
    logic [9:0] c_t, c_f, resp;

    ncl_instr_sequencer #(.TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .i_t(i_t), .i_f(i_f), .c_t(c_t), .c_f(c_f),
        .done(done), .resp(resp), .busy(busy), .err_clr(err_clr),
        .err_illegal(err_illegal), .err_timeout(err_timeout),
        .err_conflict(err_conflict)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         ph, cnt;
    logic [9:0] msk, ht0, ht1, hf0, hf1;
    logic [7:0] m_it, m_if;
    logic [9:0] m_resp;
    logic       m_done, m_ill, m_to, m_cf;

    // Controller model state
    bit         ctl_stall, ctl_hold, ctl_force, ctl_fixed, ctl_prev;
    int         ctl_age, ctl_dly, ctl_dly_max;
    logic [9:0] ctl_pat, ctl_fix_pat;

    function automatic logic [9:0] need(input logic [7:0] w);
        case (w[7:6])
            2'b11:   return 10'b11_1111_1110;
            2'b00:   return 10'b00_0000_0000;
            default: return 10'b11_1000_0001;
        endcase
    endfunction

    function automatic logic [9:0] pat_of(input logic [7:0] w);
        return {w, w[1:0]} ^ 10'h2A5;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [9:0] st, sf;
        logic [7:0] w;
        bit full, set_i, set_t, set_c;
        if (rst) begin
            mq.delete();
            ph = PH_NULL; cnt = 0; msk = '0;
            m_it = '0; m_if = '0; m_done = 0; m_resp = '0;
            m_ill = 0; m_to = 0; m_cf = 0;
            ht0 = '0; ht1 = '0; hf0 = '0; hf1 = '0;
            return;
        end
        st = ht1; sf = hf1;
        ht1 = ht0; hf1 = hf0; ht0 = c_t; hf0 = c_f;
        full  = (mq.size() >= DEPTH);
        set_i = 0; set_t = 0; set_c = |(st & sf);
        m_done = 0;
        case (ph)
            PH_IDLE: begin
                cnt = 0;
                if (mq.size() != 0) begin
                    w = mq.pop_front();
                    if (need(w) == 0) begin
                        m_done = 1; m_resp = '0; set_i = 1;
                    end else begin
                        msk = need(w); m_it = w; m_if = ~w; ph = PH_DATA;
                    end
                end
            end
            PH_DATA: begin
                if (((st ^ sf) & msk) == msk) begin
                    m_resp = st & msk; m_done = 1; m_it = '0; m_if = '0;
                    ph = PH_NULL; cnt = 0;
                end else if (cnt == TO - 1) begin
                    set_t = 1; m_it = '0; m_if = '0; ph = PH_ABORT; cnt = 0;
                end else cnt++;
            end
            default: begin
                if ((st | sf) == 0 && cnt >= 2) begin
                    ph = PH_IDLE; cnt = 0;
                end else if (cnt == TO - 1) begin
                    if (ph == PH_NULL) begin
                        set_t = 1; ph = PH_ABORT; cnt = 0;
                    end
                end else cnt++;
            end
        endcase
        if (in_valid && !full) mq.push_back(in_data);
        m_ill = (m_ill && !err_clr) || set_i;
        m_to  = (m_to && !err_clr) || set_t;
        m_cf  = (m_cf && !err_clr) || set_c;
    endtask

    task automatic check_all();
        chk("i_t", i_t, m_it);
        chk("i_f", i_f, m_if);
        chk("done", done, m_done);
        chk("resp", resp, m_resp);
        chk("busy", busy, (ph != PH_IDLE) || (mq.size() != 0));
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("err_illegal", err_illegal, m_ill);
        chk("err_timeout", err_timeout, m_to);
        chk("err_conflict", err_conflict, m_cf);
    endtask

    // Controller: answers a DATA word after ctl_dly cycles, releases after NULL.
    task automatic ctl_drive();
        bit bd;
        bd = ((m_it | m_if) != 0);
        if (bd != ctl_prev) begin
            ctl_prev = bd;
            ctl_age  = 0;
            ctl_dly  = $urandom_range(ctl_dly_max, 0);
            if (bd) ctl_pat = ctl_fixed ? ctl_fix_pat : pat_of(m_it);
        end else ctl_age++;
        if (ctl_force) return;
        if (bd) begin
            if (!ctl_stall && ctl_age >= ctl_dly) begin
                c_t = ctl_pat; c_f = ~ctl_pat;
            end
        end else if (!ctl_hold && ctl_age >= ctl_dly) begin
            c_t = '0; c_f = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        ctl_drive();
    endtask

    task automatic push(input logic [7:0] w);
        in_valid = 1'b1; in_data = w;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < limit) begin tick(); n++; end
        chk(name, n < limit, 1);
    endtask

    task automatic wait_launch(input string name, input int limit);
        int n;
        n = 0;
        while (i_t === 8'h00 && n < limit) begin tick(); n++; end
        chk(name, n < limit, 1);
    endtask

    task automatic wait_done(input string name, input int limit, output int n);
        n = 0;
        while (done !== 1'b1 && n < limit) begin tick(); n++; end
        chk(name, n < limit, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] words [5];
        int n, nd;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
        c_t = '0; c_f = '0;
        ctl_stall = 0; ctl_hold = 0; ctl_force = 0; ctl_fixed = 0; ctl_prev = 0;
        ctl_age = 0; ctl_dly = 0; ctl_dly_max = 0; ctl_pat = '0; ctl_fix_pat = '0;
        @(negedge clk);
        tick(); tick();
        chk("reset busy", busy, 1);
        chk("reset in_ready", in_ready, 1);
        chk("reset i_t", i_t, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle after reset", busy, 0);

        // 0x40: only C1i true returned
        ctl_fixed = 1; ctl_fix_pat = 10'b10_0000_0000;
        push(8'h40);
        wait_launch("026 launch", 10);
        chk("026 i_t", i_t, 8'h40);
        chk("026 i_f", i_f, 8'hBF);
        wait_done("026 done", 20, n);
        chk("026 latency", n, 3);
        chk("026 resp", resp, 10'b10_0000_0000);
        wait_idle("026 idle", 20);
        chk("026 bus null", i_t, 0);

        // 0xCF: Mr excluded from mask
        ctl_fix_pat = 10'b11_1111_0111;
        push(8'hCF);
        wait_done("027 done", 20, n);
        chk("027 resp", resp, 10'b11_1111_0110);
        wait_idle("027 idle", 20);

        // Illegal opcode
        push(8'h05);
        wait_done("028 done", 10, n);
        chk("028 resp", resp, 0);
        chk("028 bus", i_t, 0);
        tick();
        chk("028 err_illegal", err_illegal, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("028 cleared", err_illegal, 0);
        ctl_fixed = 0;

        // Controller never responds
        ctl_stall = 1;
        push(8'h81);
        wait_launch("029 launch", 10);
        n = 0; nd = 0;
        while (i_t !== 8'h00 && n < 40) begin
            n++; tick();
            if (done === 1'b1) nd++;
        end
        chk("029 data cycles", n, 16);
        chk("029 no done", nd, 0);
        chk("029 err_timeout", err_timeout, 1);
        chk("029 i_f null", i_f, 0);
        wait_idle("029 abort exit", 10);
        err_clr = 1'b1; tick(); err_clr = 1'b0;

        // Five back-to-back pushes with a stalled controller
        words = '{8'h41, 8'hC3, 8'h92, 8'hFE, 8'h5A};
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = words[k]; tick();
        end
        in_valid = 1'b0;
        chk("030 in_ready low", in_ready, 0);
        ctl_stall = 0; ctl_dly_max = 1;
        nd = 0; n = 0;
        while (nd < 5 && n < 200) begin
            tick(); n++;
            if (done === 1'b1) begin
                chk($sformatf("030 order %0d", nd), resp, pat_of(words[nd]) & need(words[nd]));
                nd++;
            end
        end
        chk("030 retired", nd, 5);
        wait_idle("030 idle", 20);

        // Reset mid-DATA with the controller holding its outputs
        ctl_dly_max = 0; ctl_hold = 1;
        push(8'h9A);
        wait_launch("031 launch", 10);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("031 bus null", i_t, 0);
        push(8'h5C);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("031 held", i_t, 0);
        end
        ctl_hold = 0;
        wait_launch("031 relaunch", 20);
        chk("031 word", i_t, 8'h5C);
        wait_idle("031 idle", 30);

        ctl_force = 1; c_t = 10'h001; c_f = 10'h001;
        tick();
        ctl_force = 0; c_t = '0; c_f = '0;
        repeat (3) tick();
        chk("031 err_conflict", err_conflict, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("031 conflict cleared", err_conflict, 0);
        wait_idle("031 settle", 20);

        // Random traffic
        ctl_dly_max = 3;
        for (int k = 0; k < 800; k++) begin
            in_valid = ($urandom_range(2, 0) == 0);
            in_data  = 8'($urandom());
            err_clr  = ($urandom_range(15, 0) == 0);
            if ($urandom_range(60, 0) == 0) begin
                ctl_force = 1; c_t[0] = 1'b1; c_f[0] = 1'b1;
            end
            tick();
            ctl_force = 0;
        end
        in_valid = 1'b0; err_clr = 1'b0;
        wait_idle("drain", 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ncl_instr_sequencer.md
NCL_INSTR_SEQUENCER -- requirements
Module: ncl_instr_sequencer

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state SHALL update on the rising edge of clk.
REQ-002 The block SHALL have parameter TIMEOUT_CYC (default 200): the maximum number of cycles each wait phase lasts before it aborts.
REQ-003 The block SHALL have parameter FIFO_DEPTH (default 4): the number of entries in the instruction queue.
REQ-004 The ports SHALL be, in order (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- in_valid, in, 1, instruction offered.
- in_data, in, 8, instruction word; bit7 maps to I7 and bit0 to I0.
- in_ready, out, 1, queue can accept an instruction.
- i_t, out, 8, true rails to the dual-rail controller.
- i_f, out, 8, false rails to the dual-rail controller.
- c_t, in, 10, true rails returned by the controller, ordered {C1i,C11,C10,C2i,C21,C20,C3i,C31,C30,Mr} from MSB to LSB.
- c_f, in, 10, false rails returned by the controller, same order as c_t.
- done, out, 1, one-cycle pulse when an instruction retires.
- resp, out, 10, captured synchronised c_t, masked to the required pairs.
- busy, out, 1, high in any state other than IDLE, or when the queue is non-empty.
- err_clr, in, 1, clears all sticky error flags.
- err_illegal, out, 1, sticky; an illegal opcode was retired.
- err_timeout, out, 1, sticky; a wait phase timed out.
- err_conflict, out, 1, sticky; both rails of a pair were seen high.

Function
REQ-005 The queue SHALL be a FIFO of FIFO_DEPTH entries; in_ready = !full; a push occurs on in_valid & in_ready.
REQ-006 There SHALL be no bypass path; a push and a pop in the same cycle SHALL leave the occupancy unchanged.
REQ-007 c_t and c_f SHALL pass through a 2-flop synchroniser; all completion and conflict checks SHALL use the synchronised values (st, sf).
REQ-008 The required-pair mask SHALL be decoded from {I7,I6} of the active word:
- 01 or 10: C1i, C11, C10, Mr.
- 11: all pairs except Mr.
- 00: illegal opcode.
REQ-009 The FSM SHALL have four states: IDLE, DATA, NULLW and ABORT.
REQ-010 In IDLE with the queue non-empty and a legal head word, the block SHALL pop the head, and at the same edge register i_t = word and i_f = ~word and enter DATA.
REQ-011 In IDLE with an illegal head word, the block SHALL pop the head, pulse done with resp = 0, set err_illegal, and stay in IDLE with the bus held NULL.
REQ-012 DATA SHALL complete when every masked pair has exactly one of st/sf high.
REQ-013 On DATA completion, at the same edge, the block SHALL capture resp = st & mask, pulse done, drive i_t = i_f = 0, and enter NULLW.
REQ-014 NULLW SHALL complete when all 20 synchronised rails are low, and SHALL then enter IDLE.
REQ-015 An 8-bit cycle counter SHALL clear on every state entry and increment on every cycle spent in DATA or NULLW.
REQ-016 If the counter reaches TIMEOUT_CYC - 1 without completion, the block SHALL set err_timeout, drive NULL, and enter ABORT; in this case done SHALL NOT pulse.
REQ-017 ABORT SHALL behave exactly as NULLW (wait for all rails low, with its own timeout).
REQ-018 If ABORT times out, the block SHALL stay in ABORT until all rails are low; it SHALL NOT re-set err_timeout in this case.
REQ-019 Any pair with st & sf high, in any state, SHALL set err_conflict; the FSM SHALL NOT react to it.
REQ-020 When err_clr and a new error event occur in the same cycle, the set SHALL win.
REQ-021 At most one instruction SHALL be in flight; the earliest a new DATA can be launched is the cycle after NULLW completes.
REQ-022 When the minimum environment delay is zero, latency from pop to done SHALL be 3 cycles (2 synchroniser cycles plus 1 registration cycle).

Reset
REQ-023 On rst, the FIFO SHALL empty, i_t = i_f = 0, done = 0, resp = 0, all error flags = 0, the counter = 0, and the state SHALL be NULLW; busy = 1 and in_ready = 1 in the cycle after reset.
REQ-024 rst asserted mid-DATA SHALL force the bus to NULL on that edge, and the block SHALL wait in NULLW for the controller's held hysteresis outputs to clear before launching anything.
REQ-025 The synchroniser flops SHALL reset to 0.

Verification
REQ-026 Push 0x40 with a controller model -> i_t=0x40 and i_f=0xBF; done after synchroniser delay with resp=10'b1000000000 (C1i_t only); bus NULL; IDLE.
REQ-027 Push 0xCF (11, I3..I0=1111) -> resp=10'b1111110110, mask excludes Mr; then a NULL handshake completes.
REQ-028 Push 0x05 (illegal) -> no bus activity; done pulse with resp=0; err_illegal=1; err_clr clears it.
REQ-029 Controller model never responds, TIMEOUT_CYC=16 -> err_timeout after 16 DATA cycles; bus NULL; no done; ABORT exits once rails are low.
REQ-030 Push 5 words back-to-back with the controller stalled -> in_ready falls after 4 (with 1 popped, falls after 5); all 5 retire in order.
REQ-031 Assert rst mid-DATA while the model holds outputs -> bus NULL at the edge; the next queued word is not launched until all c rails are 0; force c_t[0]=c_f[0]=1 -> err_conflict=1.
